riscv_single_cycle_lsu: RTL and testbench

//  Load/store unit downstream of the single-cycle datapath's dmem port; turns a datapath access into a valid/ready bus transaction.

---
 rtl/riscv_single_cycle_lsu_pkg.sv | 31 +++
 rtl/riscv_single_cycle_lsu_align.sv | 47 ++++
 rtl/riscv_single_cycle_lsu.sv | 147 ++++++++++++++
 tb/tb_riscv_single_cycle_lsu.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_single_cycle_lsu_pkg.sv
// Shared types and funct3 encodings for the single-cycle core load/store unit.
package riscv_single_cycle_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      CAUSE_MISALIGNED = 2'd0,
      CAUSE_ILLEGAL    = 2'd1,
      CAUSE_BUS_ERR    = 2'd2,
      CAUSE_TIMEOUT    = 2'd3
   } fault_cause_e;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   // Stores have no unsigned forms, so any funct3 with bit 2 set is illegal for them.
   function automatic logic is_illegal(input logic [2:0] f3, input logic is_store);
      logic ill;
      ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      return ill || (is_store && f3[2]);
   endfunction

endpackage

// File: rtl/riscv_single_cycle_lsu_align.sv
// Byte-lane steering for stores and lane extract plus sign/zero extension for loads.
module riscv_single_cycle_lsu_align
   import riscv_single_cycle_lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      case (st_size)
         2'b00: begin
            st_be    = 4'b0001 << st_off;
            st_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << {st_off[1], 1'b0};
            st_wdata = {2{st_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign shifted = ld_word >> {ld_off, 3'b000};

   always_comb begin
      ld_data = shifted;
      case (ld_funct3)
         LSU_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
         LSU_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
         LSU_BU:  ld_data = {24'd0, shifted[7:0]};
         LSU_HU:  ld_data = {16'd0, shifted[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/riscv_single_cycle_lsu.sv
// Load/store unit: datapath dmem access to valid/ready bus transaction with core stall.
// Optional response timeout is enabled with `define RVSC_LSU_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | no access in flight; decode and fault-check incoming op
// REQ      | req_valid high, request fields frozen until req_ready
// WAIT_RSP | request accepted, waiting for rsp_valid (or timeout)
// DONE     | stall released for one cycle, load data / bus fault presented
module riscv_single_cycle_lsu
   import riscv_single_cycle_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   output logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        fault_valid,
   output logic [1:0]  fault_cause,
   output logic        req_valid,
   input  logic        req_ready,
   output logic [31:0] req_addr,
   output logic        req_we,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_rdata,
   input  logic        rsp_err
);

   lsu_state_e   state;
   fault_cause_e cause;
   logic         op, illegal, misaligned, bad;
   logic [3:0]   be_nxt;
   logic [31:0]  wdata_nxt, ld_data;
   logic [1:0]   off_q;
   logic [2:0]   f3_q;
   logic         err_q, to_q, to_hit;
   logic [31:0]  rdata_q;

   assign op         = mem_read | mem_write;
   assign illegal    = is_illegal(funct3, mem_write);
   assign misaligned = ((funct3[1:0] == 2'b01) && dmem_addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (dmem_addr[1:0] != 2'b00));
   assign bad        = illegal | misaligned;
   assign stall      = op & (state != DONE) & ~bad;
   assign req_valid  = (state == REQ);
   assign dmem_rdata = rdata_q;

   riscv_single_cycle_lsu_align u_align (
      .st_size   (funct3[1:0]),
      .st_off    (dmem_addr[1:0]),
      .st_data   (dmem_wdata),
      .st_be     (be_nxt),
      .st_wdata  (wdata_nxt),
      .ld_funct3 (f3_q),
      .ld_off    (off_q),
      .ld_word   (rsp_rdata),
      .ld_data   (ld_data)
   );

`ifdef RVSC_LSU_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] to_cnt;

   // Fires on the last permitted silent WAIT_RSP cycle; a same-cycle response takes precedence.
   assign to_hit = (state == WAIT_RSP) && !rsp_valid && (to_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         to_cnt <= '0;
      else if (state == REQ && req_ready)
         to_cnt <= '0;
      else if (state == WAIT_RSP && !rsp_valid)
         to_cnt <= to_cnt + CW'(1);
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         req_addr  <= '0;
         req_we    <= 1'b0;
         req_be    <= '0;
         req_wdata <= '0;
         off_q     <= '0;
         f3_q      <= '0;
         err_q     <= 1'b0;
         to_q      <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op && !bad) begin
                  state     <= REQ;
                  req_addr  <= {dmem_addr[31:2], 2'b00};
                  req_we    <= mem_write;
                  req_be    <= be_nxt;
                  req_wdata <= wdata_nxt;
                  off_q     <= dmem_addr[1:0];
                  f3_q      <= funct3;
               end
            end
            REQ: if (req_ready) state <= WAIT_RSP;
            WAIT_RSP: begin
               if (rsp_valid) begin
                  state   <= DONE;
                  rdata_q <= (rsp_err || req_we) ? 32'd0 : ld_data;
                  err_q   <= rsp_err;
                  to_q    <= 1'b0;
               end else if (to_hit) begin
                  state   <= DONE;
                  rdata_q <= 32'd0;
                  err_q   <= 1'b0;
                  to_q    <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      fault_valid = 1'b0;
      cause       = CAUSE_MISALIGNED;
      if (state == IDLE && op && bad) begin
         fault_valid = 1'b1;
         cause       = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;
      end else if (state == DONE && (err_q || to_q)) begin
         fault_valid = 1'b1;
         cause       = to_q ? CAUSE_TIMEOUT : CAUSE_BUS_ERR;
      end
   end

   assign fault_cause = cause;

endmodule

// File: tb/tb_riscv_single_cycle_lsu.sv
// Directed, table-driven bench for the load/store unit plus reset and timeout sequences.
module tb_riscv_single_cycle_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] dmem_addr = '0, dmem_wdata = '0;
   logic [31:0] dmem_rdata;
   logic        stall, fault_valid;
   logic [1:0]  fault_cause;
   logic        req_valid, req_ready = 1'b0, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid = 1'b0, rsp_err = 1'b0;
   logic [31:0] rsp_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   riscv_single_cycle_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .stall(stall), .fault_valid(fault_valid), .fault_cause(fault_cause),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   typedef struct {
      string       name;
      logic        rd, wr;
      logic [2:0]  f3;
      logic [31:0] addr, wdata, rsp_word;
      logic        rsp_err;
      int          ready_wait;
      logic        bad;
      logic        exp_fault;
      logic [1:0]  exp_cause;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata, exp_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] rsp_word,
                               input logic rerr, input int rw, input logic bad,
                               input logic ef, input logic [1:0] ec, input logic [3:0] be,
                               input logic [31:0] ewd, input logic [31:0] erd);
      vec_t v;
      v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
      v.rsp_word = rsp_word; v.rsp_err = rerr; v.ready_wait = rw; v.bad = bad;
      v.exp_fault = ef; v.exp_cause = ec; v.exp_be = be; v.exp_wdata = ewd; v.exp_rdata = erd;
      return v;
   endfunction

   task automatic drop_op();
      mem_read = 1'b0; mem_write = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0; req_ready = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      int  wl = v.ready_wait;
      int  stalls = 0;
      bit  accepted = 0, done = 0;
      @(posedge clk); #1;
      mem_read = v.rd; mem_write = v.wr; funct3 = v.f3;
      dmem_addr = v.addr; dmem_wdata = v.wdata;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
      if (v.bad) begin
         @(negedge clk);
         check({v.name, " stall"}, 32'(stall), 32'd0);
         check({v.name, " fault_valid"}, 32'(fault_valid), 32'd1);
         check({v.name, " fault_cause"}, 32'(fault_cause), 32'(v.exp_cause));
         check({v.name, " req_valid"}, 32'(req_valid), 32'd0);
         @(posedge clk); #1;
         drop_op();
         @(negedge clk);
         check({v.name, " fault pulse end"}, 32'(fault_valid), 32'd0);
         check({v.name, " no request"}, 32'(req_valid), 32'd0);
         return;
      end
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1;
            check({v.name, " stall cycles"}, 32'(stalls), 32'(3 + v.ready_wait));
            check({v.name, " fault_valid"}, 32'(fault_valid), 32'(v.exp_fault));
            if (v.exp_fault)
               check({v.name, " fault_cause"}, 32'(fault_cause), 32'(v.exp_cause));
            check({v.name, " dmem_rdata"}, dmem_rdata, v.exp_rdata);
            drop_op();
         end else begin
            stalls++;
            if (accepted) begin
               check({v.name, " req_valid after accept"}, 32'(req_valid), 32'd0);
               req_ready = 1'b0;
               rsp_valid = 1'b1; rsp_rdata = v.rsp_word; rsp_err = v.rsp_err;
            end else if (req_valid) begin
               check({v.name, " req_addr"}, req_addr, {v.addr[31:2], 2'b00});
               check({v.name, " req_we"}, 32'(req_we), 32'(v.wr));
               check({v.name, " req_be"}, 32'(req_be), 32'(v.exp_be));
               check({v.name, " req_wdata"}, req_wdata, v.exp_wdata);
               if (wl > 0) begin
                  wl--;
                  req_ready = 1'b0;
               end else begin
                  req_ready = 1'b1;
                  accepted = 1;
               end
            end
         end
      end
      if (!done) check({v.name, " completion within budget"}, 32'd0, 32'd1);
      @(negedge clk);
      check({v.name, " rdata hold"}, dmem_rdata, v.exp_rdata);
      check({v.name, " idle fault_valid"}, 32'(fault_valid), 32'd0);
   endtask

   initial begin
      vecs.push_back(mk("LW 0x100",   1,0,3'b010,32'h100,0,32'hDEADBEEF,0,0,0,0,0,4'hF,32'h0,32'hDEADBEEF));
      vecs.push_back(mk("LB 0x103",   1,0,3'b000,32'h103,0,32'h80000000,0,0,0,0,0,4'h8,32'h0,32'hFFFFFF80));
      vecs.push_back(mk("LBU 0x103",  1,0,3'b100,32'h103,0,32'h80000000,0,0,0,0,0,4'h8,32'h0,32'h00000080));
      vecs.push_back(mk("LHU 0x102",  1,0,3'b101,32'h102,0,32'hBEEF0000,0,0,0,0,0,4'hC,32'h0,32'h0000BEEF));
      vecs.push_back(mk("LH 0x102",   1,0,3'b001,32'h102,0,32'hBEEF0000,0,0,0,0,0,4'hC,32'h0,32'hFFFFBEEF));
      vecs.push_back(mk("SH 0x206",   0,1,3'b001,32'h206,32'h1234ABCD,32'hFFFFFFFF,0,4,0,0,0,4'hC,32'hABCDABCD,32'h0));
      vecs.push_back(mk("SB 0x201",   0,1,3'b000,32'h201,32'h000000A5,32'h12345678,0,0,0,0,0,4'h2,32'hA5A5A5A5,32'h0));
      vecs.push_back(mk("SW 0x204",   0,1,3'b010,32'h204,32'h11223344,32'h0,0,1,0,0,0,4'hF,32'h11223344,32'h0));
      vecs.push_back(mk("LW misalign",1,0,3'b010,32'h101,0,0,0,0,1,1,2'd0,4'h0,32'h0,32'h0));
      vecs.push_back(mk("LH misalign",1,0,3'b001,32'h103,0,0,0,0,1,1,2'd0,4'h0,32'h0,32'h0));
      vecs.push_back(mk("f3 011",     1,0,3'b011,32'h100,0,0,0,0,1,1,2'd1,4'h0,32'h0,32'h0));
      vecs.push_back(mk("store f3 100",0,1,3'b100,32'h100,0,0,0,0,1,1,2'd1,4'h0,32'h0,32'h0));
      vecs.push_back(mk("ill+misalign",1,0,3'b111,32'h101,0,0,0,0,1,1,2'd1,4'h0,32'h0,32'h0));
      vecs.push_back(mk("LW bus err", 1,0,3'b010,32'h180,0,32'hCAFEF00D,1,0,0,1,2'd2,4'hF,32'h0,32'h0));

      #12;
      check("reset req_valid", 32'(req_valid), 32'd0);
      check("reset fault_valid", 32'(fault_valid), 32'd0);
      check("reset fault_cause", 32'(fault_cause), 32'd0);
      check("reset req_we", 32'(req_we), 32'd0);
      check("reset req_addr", req_addr, 32'd0);
      check("reset req_be", 32'(req_be), 32'd0);
      check("reset req_wdata", req_wdata, 32'd0);
      check("reset dmem_rdata", dmem_rdata, 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      foreach (vecs[i]) apply(vecs[i]);

      // Reset asserted while a load is waiting for its response.
      @(posedge clk); #1;
      mem_read = 1'b1; funct3 = 3'b010; dmem_addr = 32'h300;
      @(negedge clk);
      @(negedge clk);
      check("rst-seq in REQ", 32'(req_valid), 32'd1);
      req_ready = 1'b1;
      @(negedge clk);
      req_ready = 1'b0;
      check("rst-seq in WAIT", 32'(req_valid), 32'd0);
      rst = 1'b0;
      #1;
      check("rst-seq req_valid", 32'(req_valid), 32'd0);
      check("rst-seq rdata cleared", dmem_rdata, 32'd0);
      drop_op();
      rsp_valid = 1'b1; rsp_rdata = 32'h55555555;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst-seq stale rsp fault", 32'(fault_valid), 32'd0);
      check("rst-seq stale rsp rdata", dmem_rdata, 32'd0);
      check("rst-seq idle req_valid", 32'(req_valid), 32'd0);
      rsp_valid = 1'b0;
      apply(vecs[0]);

`ifdef RVSC_LSU_TIMEOUT_EN
      begin
         int  stalls = 0;
         bit  done = 0;
         @(posedge clk); #1;
         mem_read = 1'b1; funct3 = 3'b010; dmem_addr = 32'h400;
         for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (!stall) begin
               done = 1;
               check("timeout stall cycles", 32'(stalls), 32'd6);
               check("timeout fault_valid", 32'(fault_valid), 32'd1);
               check("timeout fault_cause", 32'(fault_cause), 32'd3);
               check("timeout dmem_rdata", dmem_rdata, 32'd0);
               drop_op();
            end else begin
               stalls++;
               req_ready = req_valid;
            end
         end
         if (!done) check("timeout completion", 32'd0, 32'd1);
         rsp_valid = 1'b0;
         @(posedge clk); #1;
         rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
         @(negedge clk);
         check("late rsp fault", 32'(fault_valid), 32'd0);
         check("late rsp rdata", dmem_rdata, 32'd0);
         rsp_valid = 1'b0;
      end
`endif

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
